// File: rtl/wb_regfile.sv
// Writeback register plus 2^RFW x DW register file with two combinational operand reads.
// Latency: capture at N, commit at the end of N+1, array read sees the value from N+2. No backpressure.
// Optional WB_BYPASS_EN forwards the WB register to the reads; without it, a hazard flag stalls issue.
module wb_regfile #(
  parameter int RFW = 5,
  parameter int IMW = 4,
  parameter int DW  = 32,
  parameter int IW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic [IW-1:0]  ex_inst,
  input  logic [DW-1:0]  ex_data,
  input  logic [IW-1:0]  id_inst,
  output logic [DW-1:0]  dataA,
  output logic [DW-1:0]  dataB,
  output logic           hazard,
  output logic           wb_valid,
  output logic [RFW-1:0] wb_addr,
  output logic [DW-1:0]  wb_data,
  output logic [31:0]    retire_cnt
);

  localparam int DEST_MSB = IW - IMW - 1;
  localparam int SRCA_MSB = DEST_MSB - RFW;
  localparam int SRCB_MSB = SRCA_MSB - RFW;
  localparam int NREGS    = 2 ** RFW;

  logic [DW-1:0]  regs [NREGS];
  logic [IMW-1:0] ex_op;
  logic [RFW-1:0] ex_dest;
  logic [RFW-1:0] srca;
  logic [RFW-1:0] srcb;
  logic           capture;
  logic           commit;
  logic [DW-1:0]  arr_a;
  logic [DW-1:0]  arr_b;
  logic           hit_a;
  logic           hit_b;

  assign ex_op   = ex_inst[IW-1 -: IMW];
  assign ex_dest = ex_inst[DEST_MSB -: RFW];
  assign srca    = id_inst[SRCA_MSB -: RFW];
  assign srcb    = id_inst[SRCB_MSB -: RFW];
  assign capture = ex_valid && (ex_op != '0);
  assign commit  = wb_valid && (wb_addr != '0);

  // Fields of the instructions that this stage does not decode.
  logic unused_fields;
  assign unused_fields = ^{ex_inst[SRCA_MSB:0], id_inst[IW-1:SRCA_MSB+1], id_inst[SRCB_MSB-RFW:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      retire_cnt <= '0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_addr <= ex_dest;
        wb_data <= ex_data;
      end
      if (wb_valid)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // The pending WB entry commits on the same edge a new result is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign arr_a = (srca == '0) ? '0 : regs[srca];
  assign arr_b = (srcb == '0) ? '0 : regs[srcb];
  assign hit_a = commit && (wb_addr == srca);
  assign hit_b = commit && (wb_addr == srcb);

`ifdef WB_BYPASS_EN
  assign dataA  = hit_a ? wb_data : arr_a;
  assign dataB  = hit_b ? wb_data : arr_b;
  assign hazard = 1'b0;
`else
  assign dataA  = arr_a;
  assign dataB  = arr_b;
  assign hazard = hit_a || hit_b;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_data;
  logic [31:0] id_inst;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        hazard;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_data(ex_data),
    .id_inst(id_inst), .dataA(dataA), .dataB(dataB), .hazard(hazard),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] d,
                                     input logic [4:0] sa, input logic [4:0] sb);
    return {op, d, sa, sb, 13'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_valid = 1'b1; ex_inst = mk(4'd3, 5'd4, 5'd0, 5'd0); ex_data = 32'hAA;
    tick();
    ex_valid = 1'b0;
    tick();
    id_inst = mk(4'd0, 5'd0, 5'd4, 5'd0);
    #1;
    checks++; if (dataA !== 32'hAA) begin errors++; $display("FAIL pre_reset_r4: got %h expected %h", dataA, 32'hAA); end
    #1 rst = 1'b1;
    #1;
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire: got %0d expected 0", retire_cnt); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_fields: got %0d/%h expected 0/0", wb_addr, wb_data); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      id_inst = mk(4'd0, 5'd0, i[4:0], i[4:0]);
      #1;
      checks++; if (dataA !== 32'd0 || dataB !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h/%h expected 0", i, dataA, dataB); end
    end
  endtask

  task automatic test_basic_write();
    id_inst = 32'd0;
    tick();
    ex_valid = 1'b1; ex_inst = 32'h8280_0000; ex_data = 32'd445;
    tick();
    ex_valid = 1'b0; ex_inst = 32'd0; id_inst = 32'h0014_0000;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_valid: got %b expected 1", wb_valid); end
    checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL basic_wb_addr: got %0d expected 5", wb_addr); end
    checks++; if (wb_data !== 32'd445) begin errors++; $display("FAIL basic_wb_data: got %0d expected 445", wb_data); end
`ifdef WB_BYPASS_EN
    checks++; if (dataA !== 32'd445 || hazard !== 1'b0) begin errors++; $display("FAIL bypass_n1: got dataA=%0d hazard=%b expected 445/0", dataA, hazard); end
`else
    checks++; if (dataA !== 32'd0 || hazard !== 1'b1) begin errors++; $display("FAIL hazard_n1: got dataA=%0d hazard=%b expected 0/1", dataA, hazard); end
`endif
    tick();
    checks++; if (dataA !== 32'd445) begin errors++; $display("FAIL basic_read_n2: got %0d expected 445", dataA); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hazard_n2: got %b expected 0", hazard); end
    checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL basic_retire: got %0d expected 1", retire_cnt); end
  endtask

  task automatic test_r0_nop();
    ex_valid = 1'b1; ex_inst = mk(4'd2, 5'd0, 5'd0, 5'd0); ex_data = 32'hDEAD_BEEF;
    id_inst = mk(4'd0, 5'd0, 5'd0, 5'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b1 || hazard !== 1'b0 || dataA !== 32'd0) begin errors++; $display("FAIL r0_wb_cycle: got valid=%b hazard=%b dataA=%h expected 1/0/0", wb_valid, hazard, dataA); end
    tick();
    checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL r0_retire: got %0d expected 2", retire_cnt); end
    checks++; if (dataA !== 32'd0) begin errors++; $display("FAIL r0_read: got %h expected 0", dataA); end
    ex_valid = 1'b1; ex_inst = mk(4'd0, 5'd5, 5'd0, 5'd0); ex_data = 32'h1234;
    tick();
    ex_valid = 1'b0; id_inst = mk(4'd0, 5'd0, 5'd5, 5'd0);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nop_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_addr !== 5'd0 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nop_wb_hold: got %0d/%h expected 0/deadbeef", wb_addr, wb_data); end
    tick();
    checks++; if (dataA !== 32'd445 || retire_cnt !== 32'd2) begin errors++; $display("FAIL nop_r5: got %0d retire=%0d expected 445/2", dataA, retire_cnt); end
  endtask

  task automatic test_back_to_back();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    id_inst = mk(4'd0, 5'd0, 5'd0, 5'd7);
    tick();
    ex_valid = 1'b1; ex_inst = mk(4'd5, 5'd7, 5'd0, 5'd0); ex_data = 32'd1;
    tick();
    ex_data = 32'd2;
    #1;
    checks++; if (wb_data !== 32'd1 || wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb1: got %0d valid=%b expected 1/1", wb_data, wb_valid); end
    tick();
    ex_data = 32'd3;
    #1;
    checks++; if (wb_data !== 32'd2) begin errors++; $display("FAIL b2b_wb2: got %0d expected 2", wb_data); end
`ifdef WB_BYPASS_EN
    checks++; if (dataB !== 32'd2 || hazard !== 1'b0) begin errors++; $display("FAIL b2b_bypass: got %0d hazard=%b expected 2/0", dataB, hazard); end
`else
    checks++; if (dataB !== 32'd1 || hazard !== 1'b1) begin errors++; $display("FAIL b2b_hazard: got %0d hazard=%b expected 1/1", dataB, hazard); end
`endif
    tick();
    ex_valid = 1'b0;
    #1;
    checks++; if (wb_data !== 32'd3) begin errors++; $display("FAIL b2b_wb3: got %0d expected 3", wb_data); end
    tick();
    checks++; if (dataB !== 32'd3) begin errors++; $display("FAIL b2b_r7: got %0d expected 3", dataB); end
    checks++; if (retire_cnt !== 32'd3) begin errors++; $display("FAIL b2b_retire: got %0d expected 3", retire_cnt); end
  endtask

  task automatic test_wrap_and_reset_midop();
    tick();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    ex_valid = 1'b1; ex_inst = mk(4'd1, 5'd3, 5'd0, 5'd0); ex_data = 32'd9;
    tick();
    ex_valid = 1'b0;
    #1;
    checks++; if (retire_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre: got %h expected ffffffff", retire_cnt); end
    tick();
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL wrap: got %h expected 0", retire_cnt); end
    ex_valid = 1'b1; ex_inst = mk(4'd1, 5'd9, 5'd0, 5'd0); ex_data = 32'h55;
    id_inst = mk(4'd0, 5'd0, 5'd9, 5'd0);
    tick();
    ex_data = 32'h66;
    #1;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9) begin errors++; $display("FAIL midop_pending: got %b/%0d expected 1/9", wb_valid, wb_addr); end
`ifndef WB_BYPASS_EN
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL midop_hazard: got %b expected 1", hazard); end
`endif
    #1 rst = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL midop_async: got %b/%b expected 0/0", wb_valid, hazard); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL midop_ignore_ex: got %b expected 0", wb_valid); end
    ex_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (dataA !== 32'd0) begin errors++; $display("FAIL midop_r9: got %h expected 0", dataA); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL midop_retire: got %0d expected 0", retire_cnt); end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_inst = 32'd0; ex_data = 32'd0; id_inst = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_basic_write();
    test_r0_nop();
    test_back_to_back();
    test_wrap_and_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
